// File: rtl/hit_arbiter_if.sv
// Tick, position and attack inputs plus result/pulse outputs of the fighter hit check.
// The arbiter takes the slave side; the game logic (or a bench) drives the master side.
interface hit_arbiter_if #(
   parameter int COORD_W = 7
);
   logic                 tick;
   logic [COORD_W-1:0]   p1_x;
   logic [COORD_W-1:0]   p1_y;
   logic [COORD_W-1:0]   p2_x;
   logic [COORD_W-1:0]   p2_y;
   logic                 p1_attack;
   logic                 p2_attack;
   logic                 busy;
   logic                 done;
   logic                 collision;
   logic [2*COORD_W:0]   dist_sq;
   logic                 p1_hit;
   logic                 p2_hit;
   logic                 clash;
   logic                 overrun;

   modport slave (
      input  tick, p1_x, p1_y, p2_x, p2_y, p1_attack, p2_attack,
      output busy, done, collision, dist_sq, p1_hit, p2_hit, clash, overrun
   );

   modport master (
      output tick, p1_x, p1_y, p2_x, p2_y, p1_attack, p2_attack,
      input  busy, done, collision, dist_sq, p1_hit, p2_hit, clash, overrun
   );
endinterface

// File: rtl/hit_arbiter.sv
// Per-tick hit check: one shared squarer forms dx^2+dy^2, then hits/cooldowns are resolved.
// Define HIT_ARB_CLASH_EN to cancel simultaneous hits as a clash instead of trading them.
module hit_arbiter #(
   parameter int COORD_W        = 7,
   parameter int HIT_RADIUS     = 20,
   parameter int COOLDOWN_TICKS = 10
) (
   input  logic          clk,
   input  logic          reset,
   hit_arbiter_if.slave  bus
);
   localparam int SQW = 2*COORD_W;
   localparam int DW  = 2*COORD_W + 1;
   localparam int CDW = $clog2(COOLDOWN_TICKS + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SQ_X    = 3'd1;
   localparam logic [2:0] S_SQ_Y    = 3'd2;
   localparam logic [2:0] S_CMP     = 3'd3;
   localparam logic [2:0] S_RESOLVE = 3'd4;

   localparam logic [DW-1:0]  R_SQ    = DW'(HIT_RADIUS * HIT_RADIUS);
   localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_TICKS);

   logic [2:0]         state_q, state_d;
   logic [COORD_W-1:0] p1x_q, p1y_q, p2x_q, p2y_q;
   logic               elig1_q, elig2_q;
   logic [CDW-1:0]     cd1_q, cd2_q;
   logic [SQW-1:0]     sq_q;
   logic [DW-1:0]      acc_q;
   logic               busy_q, done_q, coll_q, p1_hit_q, p2_hit_q, overrun_q;
   logic [DW-1:0]      dist_q;

   logic [COORD_W-1:0] dx, dy, sq_op;
   logic [SQW-1:0]     sq_res;
   logic               land1, land2;

   // Absolute differences so positions never wrap; the squarer alternates between axes.
   assign dx     = (p1x_q >= p2x_q) ? (p1x_q - p2x_q) : (p2x_q - p1x_q);
   assign dy     = (p1y_q >= p2y_q) ? (p1y_q - p2y_q) : (p2y_q - p1y_q);
   assign sq_op  = (state_q == S_SQ_X) ? dx : dy;
   assign sq_res = SQW'(sq_op) * SQW'(sq_op);

   assign land1 = coll_q && elig1_q;
   assign land2 = coll_q && elig2_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.tick) state_d = S_SQ_X;
         S_SQ_X:    state_d = S_SQ_Y;
         S_SQ_Y:    state_d = S_CMP;
         S_CMP:     state_d = S_RESOLVE;
         S_RESOLVE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

`ifdef HIT_ARB_CLASH_EN
   logic clash_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         p1x_q     <= '0;
         p1y_q     <= '0;
         p2x_q     <= '0;
         p2y_q     <= '0;
         elig1_q   <= 1'b0;
         elig2_q   <= 1'b0;
         cd1_q     <= '0;
         cd2_q     <= '0;
         sq_q      <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         coll_q    <= 1'b0;
         dist_q    <= '0;
         p1_hit_q  <= 1'b0;
         p2_hit_q  <= 1'b0;
         overrun_q <= 1'b0;
`ifdef HIT_ARB_CLASH_EN
         clash_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         done_q    <= 1'b0;
         p1_hit_q  <= 1'b0;
         p2_hit_q  <= 1'b0;
         overrun_q <= bus.tick && (state_q != S_IDLE);
`ifdef HIT_ARB_CLASH_EN
         clash_q   <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (bus.tick) begin
                  p1x_q   <= bus.p1_x;
                  p1y_q   <= bus.p1_y;
                  p2x_q   <= bus.p2_x;
                  p2y_q   <= bus.p2_y;
                  elig1_q <= bus.p1_attack && (cd1_q == '0);
                  elig2_q <= bus.p2_attack && (cd2_q == '0);
                  if (cd1_q != '0) cd1_q <= cd1_q - CDW'(1);
                  if (cd2_q != '0) cd2_q <= cd2_q - CDW'(1);
                  busy_q  <= 1'b1;
               end
            end
            S_SQ_X: sq_q  <= sq_res;
            S_SQ_Y: acc_q <= DW'(sq_q) + DW'(sq_res);
            S_CMP: begin
               dist_q <= acc_q;
               coll_q <= (acc_q < R_SQ);
            end
            S_RESOLVE: begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               if (land1) cd1_q <= CD_LOAD;
               if (land2) cd2_q <= CD_LOAD;
`ifdef HIT_ARB_CLASH_EN
               p2_hit_q <= land1 && !land2;
               p1_hit_q <= land2 && !land1;
               clash_q  <= land1 && land2;
`else
               p2_hit_q <= land1;
               p1_hit_q <= land2;
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.collision = coll_q;
   assign bus.dist_sq   = dist_q;
   assign bus.p1_hit    = p1_hit_q;
   assign bus.p2_hit    = p2_hit_q;
   assign bus.overrun   = overrun_q;
`ifdef HIT_ARB_CLASH_EN
   assign bus.clash     = clash_q;
`else
   assign bus.clash     = 1'b0;
`endif
endmodule

// File: tb/tb_hit_arbiter.sv
// Directed bench for hit_arbiter: per-cycle comparison against a tick-level model,
// plus literal expectations for the distance, bound, clash/trade, cooldown and overrun cases.
module tb_hit_arbiter;
   localparam int CW  = 7;
   localparam int R2  = 400;
   localparam int CDT = 10;
`ifdef HIT_ARB_CLASH_EN
   localparam bit CLASH = 1'b1;
`else
   localparam bit CLASH = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   hit_arbiter_if #(.COORD_W(CW)) bus ();

   hit_arbiter #(.COORD_W(CW), .HIT_RADIUS(20), .COOLDOWN_TICKS(CDT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_on = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sqdist(input int ax, input int ay, input int bx, input int by);
      int dx, dy;
      dx = (ax > bx) ? ax - bx : bx - ax;
      dy = (ay > by) ? ay - by : by - ay;
      return dx*dx + dy*dy;
   endfunction

   // Tick-level model: an accepted tick is evaluated at once, its effects
   // released on the fixed schedule (result after 3 edges, pulses after 4).
   int m_cnt = 0, m_cd1 = 0, m_cd2 = 0, pd_dist = 0, e_dist = 0;
   bit pd_el1 = 0, pd_el2 = 0;
   bit e_busy = 0, e_done = 0, e_coll = 0, e_p1 = 0, e_p2 = 0, e_cl = 0, e_ov = 0;

   always @(posedge clk) begin
      if (!reset) begin
         m_cnt <= 0; m_cd1 <= 0; m_cd2 <= 0;
         e_busy <= 0; e_done <= 0; e_coll <= 0; e_dist <= 0;
         e_p1 <= 0; e_p2 <= 0; e_cl <= 0; e_ov <= 0;
      end else begin
         e_done <= 0; e_p1 <= 0; e_p2 <= 0; e_cl <= 0; e_ov <= 0;
         if (m_cnt == 0) begin
            if (bus.tick) begin
               m_cnt   <= 4;
               e_busy  <= 1;
               pd_dist <= sqdist(int'(bus.p1_x), int'(bus.p1_y), int'(bus.p2_x), int'(bus.p2_y));
               pd_el1  <= bus.p1_attack && (m_cd1 == 0);
               pd_el2  <= bus.p2_attack && (m_cd2 == 0);
               m_cd1   <= (m_cd1 > 0) ? m_cd1 - 1 : 0;
               m_cd2   <= (m_cd2 > 0) ? m_cd2 - 1 : 0;
            end
         end else begin
            m_cnt <= m_cnt - 1;
            if (bus.tick) e_ov <= 1;
            if (m_cnt == 2) begin
               e_dist <= pd_dist;
               e_coll <= (pd_dist < R2);
            end
            if (m_cnt == 1) begin
               e_busy <= 0;
               e_done <= 1;
               if (pd_dist < R2 && pd_el1) m_cd1 <= CDT;
               if (pd_dist < R2 && pd_el2) m_cd2 <= CDT;
               e_p2 <= (pd_dist < R2) && pd_el1 && !(CLASH && pd_el2);
               e_p1 <= (pd_dist < R2) && pd_el2 && !(CLASH && pd_el1);
               e_cl <= CLASH && (pd_dist < R2) && pd_el1 && pd_el2;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("busy",      int'(bus.busy),      int'(e_busy));
         chk("done",      int'(bus.done),      int'(e_done));
         chk("collision", int'(bus.collision), int'(e_coll));
         chk("dist_sq",   int'(bus.dist_sq),   e_dist);
         chk("p1_hit",    int'(bus.p1_hit),    int'(e_p1));
         chk("p2_hit",    int'(bus.p2_hit),    int'(e_p2));
         chk("clash",     int'(bus.clash),     int'(e_cl));
         chk("overrun",   int'(bus.overrun),   int'(e_ov));
      end
   end

   // Called at a negedge; tick is sampled by the next posedge (E0).
   task automatic run_eval(input int ax, input int ay, input int bx, input int by,
                           input bit a1, input bit a2, output int lat,
                           output bit h1, output bit h2, output bit cl);
      bit got;
      bus.p1_x = 7'(ax); bus.p1_y = 7'(ay); bus.p2_x = 7'(bx); bus.p2_y = 7'(by);
      bus.p1_attack = a1; bus.p2_attack = a2;
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      got = 0; lat = -1; h1 = 0; h2 = 0; cl = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (bus.done) begin
            got = 1; lat = i;
            h1 = bus.p1_hit; h2 = bus.p2_hit; cl = bus.clash;
         end
      end
      if (!got) chk("done_timeout", 0, 1);
      $display("eval p1=(%0d,%0d) p2=(%0d,%0d) atk=%0b%0b -> dist_sq=%0d coll=%0b p1_hit=%0b p2_hit=%0b clash=%0b",
               ax, ay, bx, by, a1, a2, bus.dist_sq, bus.collision, h1, h2, cl);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int  lat, hits;
      bit  h1, h2, cl, seen;
      bus.tick = 0; bus.p1_attack = 0; bus.p2_attack = 0;
      bus.p1_x = 0; bus.p1_y = 0; bus.p2_x = 0; bus.p2_y = 0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_dist", int'(bus.dist_sq), 0);
      chk("rst_coll", int'(bus.collision), 0);
      reset = 1'b1;
      cmp_on = 1'b1;

      // 1) in range, single attacker
      run_eval(10, 50, 25, 50, 1, 0, lat, h1, h2, cl);
      chk("t1_latency", lat, 3);
      chk("t1_dist", int'(bus.dist_sq), 225);
      chk("t1_coll", int'(bus.collision), 1);
      chk("t1_p2_hit", int'(h2), 1);
      chk("t1_p1_hit", int'(h1), 0);
      // 2) exactly on the radius: strict bound
      run_eval(30, 40, 50, 40, 1, 0, lat, h1, h2, cl);
      chk("t2_dist", int'(bus.dist_sq), 400);
      chk("t2_coll", int'(bus.collision), 0);
      chk("t2_p2_hit", int'(h2), 0);
      // 3) opposite corners: absolute difference, no wrap
      run_eval(0, 0, 127, 127, 0, 0, lat, h1, h2, cl);
      chk("t3_dist", int'(bus.dist_sq), 32258);
      chk("t3_coll", int'(bus.collision), 0);

      // 4) simultaneous attacks, then both must be on cooldown
      do_reset();
      run_eval(10, 10, 12, 10, 1, 1, lat, h1, h2, cl);
      chk("t4_dist", int'(bus.dist_sq), 4);
      chk("t4_clash", int'(cl), CLASH ? 1 : 0);
      chk("t4_p1_hit", int'(h1), CLASH ? 0 : 1);
      chk("t4_p2_hit", int'(h2), CLASH ? 0 : 1);
      run_eval(10, 10, 12, 10, 1, 1, lat, h1, h2, cl);
      chk("t4_cd_hits", int'(h1) + int'(h2) + int'(cl), 0);

      // 5) held attack: hits only on ticks 1 and 12, ticks back-to-back
      do_reset();
      hits = 0;
      for (int k = 1; k <= 12; k++) begin
         run_eval(10, 50, 25, 50, 1, 0, lat, h1, h2, cl);
         chk($sformatf("t5_tick%0d_p2_hit", k), int'(h2), (k == 1 || k == 12) ? 1 : 0);
         hits += int'(h2);
      end
      chk("t5_hit_count", hits, 2);

      // 6a) tick at E2 is dropped with an overrun pulse
      do_reset();
      bus.p1_x = 10; bus.p1_y = 50; bus.p2_x = 25; bus.p2_y = 50;
      bus.p1_attack = 1; bus.p2_attack = 0;
      bus.tick = 1;
      @(negedge clk); bus.tick = 0;
      @(negedge clk); bus.tick = 1;
      @(negedge clk); bus.tick = 0;
      chk("t6_overrun", int'(bus.overrun), 1);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1;
            chk("t6_dist", int'(bus.dist_sq), 225);
            chk("t6_p2_hit", int'(bus.p2_hit), 1);
         end
      end
      if (!seen) chk("t6_done_timeout", 0, 1);
      @(negedge clk);
      chk("t6_no_second_eval", int'(bus.busy), 0);
      $display("overrun case: tick at E2 dropped, dist_sq=%0d", bus.dist_sq);

      // 6b) reset at E2 discards the evaluation
      bus.tick = 1;
      @(negedge clk); bus.tick = 0;
      @(negedge clk); reset = 0;
      @(negedge clk); reset = 1;
      chk("t6r_busy", int'(bus.busy), 0);
      chk("t6r_dist", int'(bus.dist_sq), 0);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done || bus.p2_hit) seen = 1;
      end
      chk("t6r_no_done", int'(seen), 0);
      $display("reset case: mid-evaluation reset, done seen=%0b", seen);

      cmp_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
